// File: rtl/hazard_if.sv
// Signal bundle between the pipeline datapath and the hazard unit.
// The hazard unit takes the slave view; the datapath (or a bench) takes the master view.
interface hazard_if;
    logic        MemRead_IDEX;
    logic        RegWrite_IDEX;
    logic        FlagWrite_IDEX;
    logic [3:0]  DstReg1_in_from_IDEX;
    logic        MemRead_EXMEM;
    logic [3:0]  DstReg1_in_from_EXMEM;
    logic [3:0]  SrcReg1_in_from_IFID;
    logic [3:0]  SrcReg2_in_from_IFID;
    logic        UseSrc1_IFID;
    logic        UseSrc2_IFID;
    logic        Branch_IFID;
    logic        BranchReg_IFID;
    logic        BranchTaken_ID;
    logic        Halt_IFID;
    logic        imem_stall;
    logic        dmem_stall;
    logic        PC_write;
    logic        IFID_write;
    logic        IDEX_write;
    logic        IFID_flush;
    logic        IDEX_flush;
    logic        EXMEM_write;
    logic        MEMWB_write;
    logic        halted;
    logic [15:0] stall_cycles;
    logic [15:0] bubble_count;
    logic        hazard_err;

    modport slave (
        input  MemRead_IDEX, RegWrite_IDEX, FlagWrite_IDEX, DstReg1_in_from_IDEX,
               MemRead_EXMEM, DstReg1_in_from_EXMEM,
               SrcReg1_in_from_IFID, SrcReg2_in_from_IFID, UseSrc1_IFID, UseSrc2_IFID,
               Branch_IFID, BranchReg_IFID, BranchTaken_ID, Halt_IFID,
               imem_stall, dmem_stall,
        output PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush,
               EXMEM_write, MEMWB_write, halted, stall_cycles, bubble_count, hazard_err
    );

    modport master (
        output MemRead_IDEX, RegWrite_IDEX, FlagWrite_IDEX, DstReg1_in_from_IDEX,
               MemRead_EXMEM, DstReg1_in_from_EXMEM,
               SrcReg1_in_from_IFID, SrcReg2_in_from_IFID, UseSrc1_IFID, UseSrc2_IFID,
               Branch_IFID, BranchReg_IFID, BranchTaken_ID, Halt_IFID,
               imem_stall, dmem_stall,
        input  PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush,
               EXMEM_write, MEMWB_write, halted, stall_cycles, bubble_count, hazard_err
    );
endinterface

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use and ID-branch hazards,
// cache-miss freezes, HLT drain, plus saturating stall statistics and a sticky error flag.
module hazard_unit #(
    parameter int unsigned MAX_BUBBLES = 2
) (
    input logic     clk,
    input logic     rst_n,
    hazard_if.slave hz
);
    localparam int unsigned   BW        = $clog2(MAX_BUBBLES + 2);
    localparam logic [BW-1:0] BUB_LIMIT = BW'(MAX_BUBBLES + 1);

    typedef enum logic [2:0] {RUN, DWAIT, IWAIT, HAZ, DRAIN, HALTED} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_drain;
    logic [BW-1:0] r_bub_run;
    logic [BW-1:0] w_bub_run_next;
    logic          r_err;
    logic [15:0]   r_stall;
    logic [15:0]   r_bubbles;

    logic w_ex_dst_nz, w_mem_dst_nz, w_lu, w_brh, w_hz;
    logic w_pc, w_ifid_w, w_idex_w, w_exmem_w, w_memwb_w, w_ifid_f, w_idex_f;

    assign w_ex_dst_nz  = |hz.DstReg1_in_from_IDEX;
    assign w_mem_dst_nz = |hz.DstReg1_in_from_EXMEM;

    assign w_lu = hz.MemRead_IDEX & hz.RegWrite_IDEX & w_ex_dst_nz &
                  ((hz.UseSrc1_IFID & (hz.SrcReg1_in_from_IFID == hz.DstReg1_in_from_IDEX)) |
                   (hz.UseSrc2_IFID & (hz.SrcReg2_in_from_IFID == hz.DstReg1_in_from_IDEX)));

    assign w_brh = hz.Branch_IFID &
                   (hz.FlagWrite_IDEX |
                    (hz.BranchReg_IFID &
                     ((hz.RegWrite_IDEX & w_ex_dst_nz &
                       (hz.SrcReg1_in_from_IFID == hz.DstReg1_in_from_IDEX)) |
                      (hz.MemRead_EXMEM & w_mem_dst_nz &
                       (hz.SrcReg1_in_from_IFID == hz.DstReg1_in_from_EXMEM)))));

    assign w_hz = w_lu | w_brh;

    always_comb begin
        w_pc      = 1'b1;
        w_ifid_w  = 1'b1;
        w_idex_w  = 1'b1;
        w_exmem_w = 1'b1;
        w_memwb_w = 1'b1;
        w_ifid_f  = 1'b0;
        w_idex_f  = 1'b0;
        w_next    = r_state;
        if (rst_n) begin
            case (r_state)
                HALTED: begin
                    w_pc     = 1'b0;
                    w_ifid_f = 1'b1;
                end
                DRAIN: begin
                    if (hz.dmem_stall) begin
                        w_pc      = 1'b0;
                        w_ifid_w  = 1'b0;
                        w_idex_w  = 1'b0;
                        w_exmem_w = 1'b0;
                        w_memwb_w = 1'b0;
                    end else begin
                        w_pc     = 1'b0;
                        w_ifid_f = 1'b1;
                        if (r_drain == 2'd2) w_next = HALTED;
                    end
                end
                // RUN, DWAIT, IWAIT and HAZ share the same priority decode.
                default: begin
                    if (hz.dmem_stall) begin
                        w_pc      = 1'b0;
                        w_ifid_w  = 1'b0;
                        w_idex_w  = 1'b0;
                        w_exmem_w = 1'b0;
                        w_memwb_w = 1'b0;
                        w_next    = DWAIT;
                    end else if (hz.imem_stall) begin
                        w_pc     = 1'b0;
                        w_ifid_f = 1'b1;
                        w_next   = IWAIT;
                    end else if (w_hz) begin
                        w_pc     = 1'b0;
                        w_ifid_w = 1'b0;
                        w_idex_f = 1'b1;
                        w_next   = HAZ;
                    end else if (hz.BranchTaken_ID) begin
                        w_ifid_f = 1'b1;
                        w_next   = RUN;
                    end else if (hz.Halt_IFID) begin
                        w_pc     = 1'b0;
                        w_ifid_f = 1'b1;
                        w_next   = DRAIN;
                    end else begin
                        w_next = RUN;
                    end
                end
            endcase
        end
    end

    // Stall cycles freeze the consecutive-bubble run rather than breaking it.
    always_comb begin
        w_bub_run_next = r_bub_run;
        if (w_idex_f) begin
            if (r_bub_run != BUB_LIMIT) w_bub_run_next = r_bub_run + 1'b1;
        end else if (!(hz.dmem_stall | hz.imem_stall)) begin
            w_bub_run_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_drain   <= '0;
            r_bub_run <= '0;
            r_err     <= 1'b0;
            r_stall   <= '0;
            r_bubbles <= '0;
        end else begin
            r_state   <= w_next;
            if (r_state != DRAIN)      r_drain <= '0;
            else if (!hz.dmem_stall)   r_drain <= r_drain + 2'd1;
            r_bub_run <= w_bub_run_next;
            if (w_bub_run_next == BUB_LIMIT) r_err <= 1'b1;
            if (!w_pc && (r_state != HALTED) && (r_stall != '1)) r_stall <= r_stall + 16'd1;
            if (w_idex_f && (r_bubbles != '1)) r_bubbles <= r_bubbles + 16'd1;
        end
    end

    assign hz.PC_write     = w_pc;
    assign hz.IFID_write   = w_ifid_w;
    assign hz.IDEX_write   = w_idex_w;
    assign hz.EXMEM_write  = w_exmem_w;
    assign hz.MEMWB_write  = w_memwb_w;
    assign hz.IFID_flush   = w_ifid_f;
    assign hz.IDEX_flush   = w_idex_f;
    assign hz.halted       = (r_state == HALTED);
    assign hz.stall_cycles = r_stall;
    assign hz.bubble_count = r_bubbles;
    assign hz.hazard_err   = r_err;
endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vector table, multi-cycle sequences and a
// randomized run against a register-bitmask reference model.
module tb_hazard_unit;
    logic clk;
    logic rst_n;
    hazard_if u_if ();

    hazard_unit #(.MAX_BUBBLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mr, rw, fw;
        logic [3:0] dex;
        logic       mem;
        logic [3:0] dem;
        logic [3:0] s1, s2;
        logic       u1, u2, br, brr, bt, hlt, im, dm;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [6:0] exp;
    } vec_t;

    // Output vector order: {PC, IFIDw, IDEXw, EXMEMw, MEMWBw, IFIDf, IDEXf}
    localparam logic [6:0] O_IDLE = 7'b1111100;
    localparam logic [6:0] O_BUB  = 7'b0011101;
    localparam logic [6:0] O_FRZ  = 7'b0000000;
    localparam logic [6:0] O_PCF  = 7'b0111110;
    localparam logic [6:0] O_TKN  = 7'b1111110;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int   m_phase;   // 0 running, 1 draining, 2 halted
    int   m_drained;
    int   m_run;
    bit   m_err;
    int   m_stall;
    int   m_bub;

    function automatic in_t mk(logic mr, logic rw, logic fw, logic [3:0] dex,
                               logic mem, logic [3:0] dem, logic [3:0] s1, logic [3:0] s2,
                               logic u1, logic u2, logic br, logic brr, logic bt,
                               logic hlt, logic im, logic dm);
        in_t v;
        v.mr = mr; v.rw = rw; v.fw = fw; v.dex = dex; v.mem = mem; v.dem = dem;
        v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2; v.br = br; v.brr = brr;
        v.bt = bt; v.hlt = hlt; v.im = im; v.dm = dm;
        return v;
    endfunction

    function automatic vec_t mv(string n, in_t i, logic [6:0] e);
        vec_t r;
        r.name = n; r.in = i; r.exp = e;
        return r;
    endfunction

    task automatic drive(in_t v);
        u_if.MemRead_IDEX          = v.mr;
        u_if.RegWrite_IDEX         = v.rw;
        u_if.FlagWrite_IDEX        = v.fw;
        u_if.DstReg1_in_from_IDEX  = v.dex;
        u_if.MemRead_EXMEM         = v.mem;
        u_if.DstReg1_in_from_EXMEM = v.dem;
        u_if.SrcReg1_in_from_IFID  = v.s1;
        u_if.SrcReg2_in_from_IFID  = v.s2;
        u_if.UseSrc1_IFID          = v.u1;
        u_if.UseSrc2_IFID          = v.u2;
        u_if.Branch_IFID           = v.br;
        u_if.BranchReg_IFID        = v.brr;
        u_if.BranchTaken_ID        = v.bt;
        u_if.Halt_IFID             = v.hlt;
        u_if.imem_stall            = v.im;
        u_if.dmem_stall            = v.dm;
    endtask

    function automatic logic [6:0] outv();
        return {u_if.PC_write, u_if.IFID_write, u_if.IDEX_write, u_if.EXMEM_write,
                u_if.MEMWB_write, u_if.IFID_flush, u_if.IDEX_flush};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_phase = 0; m_drained = 0; m_run = 0; m_err = 0; m_stall = 0; m_bub = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive('0);
        step();
        rst_n = 1'b1;
        m_reset();
    endtask

    // Hazard test via register-set bitmasks.
    function automatic bit m_hz(in_t v);
        logic [15:0] ld, rd, wr;
        ld = (v.mr && v.rw) ? (16'(1) << v.dex) : 16'h0;
        rd = (v.u1 ? (16'(1) << v.s1) : 16'h0) | (v.u2 ? (16'(1) << v.s2) : 16'h0);
        wr = (v.rw ? (16'(1) << v.dex) : 16'h0) | (v.mem ? (16'(1) << v.dem) : 16'h0);
        ld[0] = 1'b0;
        wr[0] = 1'b0;
        return ((ld & rd) != 16'h0) || (v.br && (v.fw || (v.brr && wr[v.s1])));
    endfunction

    function automatic logic [6:0] m_out(in_t v, logic rst);
        if (!rst)          return O_IDLE;
        if (m_phase == 2)  return O_PCF;
        if (v.dm)          return O_FRZ;
        if (m_phase == 1)  return O_PCF;
        if (v.im)          return O_PCF;
        if (m_hz(v))       return O_BUB;
        if (v.bt)          return O_TKN;
        if (v.hlt)         return O_PCF;
        return O_IDLE;
    endfunction

    task automatic m_edge(in_t v, logic rst, logic [6:0] o);
        if (!rst) begin
            m_reset();
            return;
        end
        if (!o[6] && m_phase != 2 && m_stall < 65535) m_stall++;
        if (o[0] && m_bub < 65535) m_bub++;
        if (o[0]) m_run = (m_run < 3) ? m_run + 1 : 3;
        else if (!(v.dm || v.im)) m_run = 0;
        if (m_run >= 3) m_err = 1;
        if (m_phase == 0) begin
            if (!v.dm && !v.im && !m_hz(v) && !v.bt && v.hlt) begin
                m_phase = 1; m_drained = 0;
            end
        end else if (m_phase == 1 && !v.dm) begin
            m_drained++;
            if (m_drained == 3) m_phase = 2;
        end
    endtask

    function automatic in_t rnd_in();
        in_t v;
        v.mr  = ($urandom_range(0, 2) == 0);
        v.rw  = ($urandom_range(0, 1) == 0);
        v.fw  = ($urandom_range(0, 5) == 0);
        v.dex = 4'($urandom_range(0, 3));
        v.mem = ($urandom_range(0, 2) == 0);
        v.dem = 4'($urandom_range(0, 3));
        v.s1  = 4'($urandom_range(0, 3));
        v.s2  = 4'($urandom_range(0, 3));
        v.u1  = ($urandom_range(0, 1) == 0);
        v.u2  = ($urandom_range(0, 1) == 0);
        v.br  = ($urandom_range(0, 3) == 0);
        v.brr = ($urandom_range(0, 1) == 0);
        v.bt  = ($urandom_range(0, 5) == 0);
        v.hlt = ($urandom_range(0, 24) == 0);
        v.im  = ($urandom_range(0, 7) == 0);
        v.dm  = ($urandom_range(0, 7) == 0);
        return v;
    endfunction

    vec_t vecs[$];
    in_t  v_lu, v_idle, v_halt, v_brflag, rv;
    logic [6:0] eo;
    logic rr;

    initial begin
        rst_n = 1'b0;
        drive('0);

        vecs.push_back(mv("idle",       mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0,0), O_IDLE));
        vecs.push_back(mv("lu_src1",    mk(1,1,0,3, 0,0, 3,7,1,1, 0,0,0,0,0,0), O_BUB));
        vecs.push_back(mv("lu_src2",    mk(1,1,0,4, 0,0, 2,4,1,1, 0,0,0,0,0,0), O_BUB));
        vecs.push_back(mv("lu_unused",  mk(1,1,0,4, 0,0, 2,4,1,0, 0,0,0,0,0,0), O_IDLE));
        vecs.push_back(mv("lu_r0",      mk(1,1,0,0, 0,0, 0,0,1,1, 0,0,0,0,0,0), O_IDLE));
        vecs.push_back(mv("load_norw",  mk(1,0,0,3, 0,0, 3,3,1,1, 0,0,0,0,0,0), O_IDLE));
        vecs.push_back(mv("alu_in_ex",  mk(0,1,0,3, 0,0, 3,3,1,1, 0,0,0,0,0,0), O_IDLE));
        vecs.push_back(mv("br_flag",    mk(0,0,1,0, 0,0, 0,0,0,0, 1,0,0,0,0,0), O_BUB));
        vecs.push_back(mv("flag_nobr",  mk(0,0,1,0, 0,0, 0,0,0,0, 0,0,0,0,0,0), O_IDLE));
        vecs.push_back(mv("br_ex",      mk(0,1,0,5, 0,0, 5,0,1,0, 1,1,0,0,0,0), O_BUB));
        vecs.push_back(mv("br_mem",     mk(0,0,0,0, 1,5, 5,0,1,0, 1,1,0,0,0,0), O_BUB));
        vecs.push_back(mv("br_mem_nold",mk(0,0,0,0, 0,5, 5,0,1,0, 1,1,0,0,0,0), O_IDLE));
        vecs.push_back(mv("b_regmatch", mk(0,1,0,5, 1,5, 5,0,0,0, 1,0,0,0,0,0), O_IDLE));
        vecs.push_back(mv("br_r0",      mk(0,1,0,0, 1,0, 0,0,1,0, 1,1,0,0,0,0), O_IDLE));
        vecs.push_back(mv("taken",      mk(0,0,0,0, 0,0, 0,0,0,0, 1,0,1,0,0,0), O_TKN));
        vecs.push_back(mv("imem",       mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,1,0), O_PCF));
        vecs.push_back(mv("dmem",       mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0,1), O_FRZ));
        vecs.push_back(mv("dmem_lu",    mk(1,1,0,3, 0,0, 3,0,1,0, 0,0,0,0,0,1), O_FRZ));
        vecs.push_back(mv("imem_lu",    mk(1,1,0,3, 0,0, 3,0,1,0, 0,0,0,0,1,0), O_PCF));
        vecs.push_back(mv("lu_taken",   mk(1,1,0,3, 0,0, 3,0,1,0, 0,0,1,0,0,0), O_BUB));
        vecs.push_back(mv("taken_halt", mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,1,1,0,0), O_TKN));
        vecs.push_back(mv("halt",       mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,0,1,0,0), O_PCF));

        v_idle   = '0;
        v_lu     = mk(1,1,0,3, 0,0, 3,0,1,0, 0,0,0,0,0,0);
        v_halt   = mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,0,1,0,0);
        v_brflag = mk(0,0,1,0, 0,0, 0,0,0,0, 1,0,0,0,0,0);

        // Reset state (outputs forced while rst_n low)
        #2;
        chk("rst_forced", 64'(outv()), 64'(O_IDLE));
        step();
        rst_n = 1'b1;
        chk("rst_counters", {u_if.halted, u_if.hazard_err, u_if.stall_cycles, u_if.bubble_count},
            64'h0);

        foreach (vecs[i]) begin
            do_reset();
            drive(vecs[i].in);
            #3;
            chk(vecs[i].name, 64'(outv()), 64'(vecs[i].exp));
        end

        // Load-use: exactly one bubble
        do_reset();
        drive(v_lu); #3;
        chk("lu_seq_c0", 64'(outv()), 64'(O_BUB));
        step(); drive(v_idle); #3;
        chk("lu_seq_c1", 64'(outv()), 64'(O_IDLE));
        chk("lu_seq_bub", 64'(u_if.bubble_count), 64'd1);

        // BR via R5 with a load to R5 in EX: two bubbles, no error
        do_reset();
        drive(mk(1,1,0,5, 0,0, 5,0,1,0, 1,1,0,0,0,0)); #3;
        chk("br2_c0", 64'(outv()), 64'(O_BUB));
        step();
        drive(mk(0,0,0,0, 1,5, 5,0,1,0, 1,1,0,0,0,0)); #3;
        chk("br2_c1", 64'(outv()), 64'(O_BUB));
        step(); drive(v_idle); #3;
        chk("br2_pc", 64'(u_if.PC_write), 64'd1);
        chk("br2_err", 64'(u_if.hazard_err), 64'd0);
        chk("br2_bub", 64'(u_if.bubble_count), 64'd2);

        // dmem_stall over a pending load-use
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(mk(1,1,0,3, 0,0, 3,0,1,0, 0,0,0,0,0,1)); #3;
            chk("dm_lu_frz", 64'(outv()), 64'(O_FRZ));
            step();
        end
        drive(v_lu); #3;
        chk("dm_lu_bub", 64'(outv()), 64'(O_BUB));
        step(); drive(v_idle); #3;
        chk("dm_lu_after", 64'(outv()), 64'(O_IDLE));
        chk("dm_lu_stall", 64'(u_if.stall_cycles), 64'd5);
        chk("dm_lu_bcnt", 64'(u_if.bubble_count), 64'd1);

        // HLT drain, halted hold under random inputs, then reset
        do_reset();
        drive(v_halt); #3;
        chk("hlt_c0", 64'(outv()), 64'(O_PCF));
        step(); drive(v_idle);
        for (int c = 0; c < 3; c++) begin
            #3;
            chk("hlt_drain", {outv(), u_if.halted}, {O_PCF, 1'b0});
            step();
        end
        chk("hlt_halted", 64'(u_if.halted), 64'd1);
        for (int c = 0; c < 20; c++) begin
            drive(rnd_in()); #3;
            chk("hlt_hold", {outv(), u_if.halted}, {O_PCF, 1'b1});
            step();
        end
        chk("hlt_stall", 64'(u_if.stall_cycles), 64'd4);
        rst_n = 1'b0; drive(v_idle); #3;
        chk("hlt_rst_forced", 64'(outv()), 64'(O_IDLE));
        step(); rst_n = 1'b1; #3;
        chk("hlt_rst_exit", {u_if.halted, u_if.PC_write}, {1'b0, 1'b1});

        // dmem_stall during DRAIN freezes the drain count
        do_reset();
        drive(v_halt); step();
        drive(v_idle); #3;
        chk("drfz_d1", 64'(outv()), 64'(O_PCF));
        step();
        for (int c = 0; c < 2; c++) begin
            drive(mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0,1)); #3;
            chk("drfz_frz", {outv(), u_if.halted}, {O_FRZ, 1'b0});
            step();
        end
        drive(v_idle);
        for (int c = 0; c < 2; c++) begin
            #3;
            chk("drfz_drain", {outv(), u_if.halted}, {O_PCF, 1'b0});
            step();
        end
        chk("drfz_halted", 64'(u_if.halted), 64'd1);
        chk("drfz_stall", 64'(u_if.stall_cycles), 64'd6);

        // Three consecutive hazards set the sticky error
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(v_brflag); step();
            chk("err_edge", 64'(u_if.hazard_err), (c == 2) ? 64'd1 : 64'd0);
        end
        drive(v_idle); step(); step();
        chk("err_sticky", 64'(u_if.hazard_err), 64'd1);

        // Randomized run against the reference model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rr = ($urandom_range(0, 39) != 0);
            rv = rnd_in();
            rst_n = rr;
            drive(rv);
            #3;
            eo = m_out(rv, rr);
            chk("rand_out", 64'(outv()), 64'(eo));
            chk("rand_state", {u_if.halted, u_if.hazard_err, u_if.stall_cycles, u_if.bubble_count},
                {(m_phase == 2), m_err, 16'(m_stall), 16'(m_bub)});
            m_edge(rv, rr, eo);
            step();
        end
        rst_n = 1'b1;

        // stall_cycles saturation under a long imem_stall
        do_reset();
        drive(mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,1,0));
        repeat (70000) @(posedge clk);
        #1;
        chk("stall_sat", 64'(u_if.stall_cycles), 64'hFFFF);
        chk("stall_sat_bub", 64'(u_if.bubble_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
